seg7_scan: RTL and testbench



---
 rtl/seg7_scan_if.sv | 25 ++
 rtl/seg7_scan.sv | 142 ++++++++++++++
 tb/tb_seg7_scan.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Bus bundle between the display driver and whatever feeds it.
// The master side supplies the word and the status controls; the slave side
// (the scan engine) returns the multiplexed display drive plus its scan
// position, which is exposed so checkers can bind to the internal state.
interface seg7_scan_if;
    logic [31:0] value;       // word to display
    logic        dp_flag;     // light decimal point on digit 0
    logic        blank_lz;    // enable leading-zero blanking
    logic [7:0]  an;          // digit enables, active-low
    logic [6:0]  seg;         // segments {g,f,e,d,c,b,a}, active-low
    logic        dp;          // decimal point, active-low
    logic        frame;       // one-cycle pulse after a shadow reload
    logic [2:0]  dbg_idx;     // current digit index (state)
    logic [31:0] dbg_shadow;  // currently latched display word (state)

    modport master (
        output value, dp_flag, blank_lz,
        input  an, seg, dp, frame, dbg_idx, dbg_shadow
    );

    modport slave (
        input  value, dp_flag, blank_lz,
        output an, seg, dp, frame, dbg_idx, dbg_shadow
    );
endinterface

// File: rtl/seg7_scan.sv
// Eight-digit common-anode seven-segment scanner.
// One digit is enabled at a time for SCAN_DIV cycles. The displayed word is
// copied into a shadow register only when the scan wraps from digit 7 to
// digit 0, so a single frame never mixes two different values.
// Handshake: there is no valid/ready pair; value is sampled only on the
// frame-wrap tick and ignored otherwise, while dp_flag/blank_lz are sampled
// every cycle. SCAN_DIV must be at least 2.
module seg7_scan #(
    parameter int SCAN_DIV = 100000
) (
    input  logic         clk,
    input  logic         rst,
    seg7_scan_if.slave   bus
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0]       IDX_LAST = 3'd7;

    // Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Scan state
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       idx_q,    idx_d;
    logic [31:0]      shadow_q, shadow_d;

    // Registered display outputs
    logic [7:0]       an_q,     an_d;
    logic [6:0]       seg_q,    seg_d;
    logic             dp_q,     dp_d;
    logic             frame_q,  frame_d;

    // Decode helpers
    logic             tick;
    logic             wrap;
    logic [4:0]       bit_base;
    logic [3:0]       nib;
    logic [31:0]      upper_mask;
    logic             blank;

    // Divider tick, frame wrap and the nibble/blank decode for the current digit.
    always_comb begin
        tick       = (cnt_q == CNT_MAX);
        wrap       = tick && (idx_q == IDX_LAST);
        bit_base   = {idx_q, 2'b00};
        nib        = shadow_q[bit_base +: 4];
        // Covers nibbles idx..7: the digit is a leading zero only if all of
        // them are zero. Digit 0 always shows, so a zero word reads "0".
        upper_mask = 32'hFFFF_FFFF << bit_base;
        blank      = bus.blank_lz && (idx_q != 3'd0) &&
                     ((shadow_q & upper_mask) == 32'h0);
    end

    // Next-state for divider, digit index, shadow word and frame pulse.
    always_comb begin
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        shadow_d = shadow_q;
        frame_d  = 1'b0;
        if (tick) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
        if (wrap) begin
            shadow_d = bus.value;
            frame_d  = 1'b1;
        end
    end

    // Next display drive, computed from the state before this edge so the
    // outputs lag the scan state by exactly one cycle.
    always_comb begin
        an_d  = 8'hFF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (!blank) begin
            an_d  = ~(8'h01 << idx_q);
            seg_d = hex_to_seg(nib);
        end
        if (bus.dp_flag && (idx_q == 3'd0)) begin
            dp_d = 1'b0;
        end
    end

    // Scan state registers; reset restarts the frame at digit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            shadow_q <= 32'h0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
        end
    end

    // Output registers; reset blanks the display and drops any pending frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame      = frame_q;
    assign bus.dbg_idx    = idx_q;
    assign bus.dbg_shadow = shadow_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan with SCAN_DIV = 4 (frame = 32 cycles).
module tb_seg7_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg7_scan_if bus();

    seg7_scan #(.SCAN_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] value;
        logic        blz;
        logic        dpf;
        int          digit;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    vec_t vecs[$];

    // Advance one clock and settle just after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hold reset for three edges with the given inputs, then release.
    task automatic do_reset(input logic [31:0] v, input logic blz, input logic dpf);
        bus.value    = v;
        bus.blank_lz = blz;
        bus.dp_flag  = dpf;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
    endtask

    // Step until frame is seen high; returns the number of steps taken.
    task automatic wait_frame(input string name, output int steps);
        steps = 0;
        do begin
            step(1);
            steps++;
        end while (bus.frame !== 1'b1 && steps < 100);
        if (bus.frame !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: frame timeout after %0d cycles", name, steps);
        end
    endtask

    initial begin
        int s;
        logic [7:0] e_an;
        logic [6:0] scan_seg [8];

        bus.value    = 32'h0;
        bus.blank_lz = 1'b0;
        bus.dp_flag  = 1'b0;

        // Directed vectors: digit positions counted after the frame pulse.
        vecs.push_back('{32'h1234ABCD, 1'b0, 1'b0, 0, 8'hFE, 7'h21, 1'b1});
        vecs.push_back('{32'h1234ABCD, 1'b0, 1'b0, 1, 8'hFD, 7'h46, 1'b1});
        vecs.push_back('{32'h1234ABCD, 1'b0, 1'b0, 2, 8'hFB, 7'h03, 1'b1});
        vecs.push_back('{32'h1234ABCD, 1'b0, 1'b0, 3, 8'hF7, 7'h08, 1'b1});
        vecs.push_back('{32'h1234ABCD, 1'b0, 1'b0, 4, 8'hEF, 7'h19, 1'b1});
        vecs.push_back('{32'h1234ABCD, 1'b0, 1'b0, 5, 8'hDF, 7'h30, 1'b1});
        vecs.push_back('{32'h1234ABCD, 1'b0, 1'b0, 6, 8'hBF, 7'h24, 1'b1});
        vecs.push_back('{32'h1234ABCD, 1'b0, 1'b0, 7, 8'h7F, 7'h79, 1'b1});
        vecs.push_back('{32'h00000022, 1'b1, 1'b0, 0, 8'hFE, 7'h24, 1'b1});
        vecs.push_back('{32'h00000022, 1'b1, 1'b0, 1, 8'hFD, 7'h24, 1'b1});
        vecs.push_back('{32'h00000022, 1'b1, 1'b0, 2, 8'hFF, 7'h7F, 1'b1});
        vecs.push_back('{32'h00000022, 1'b1, 1'b0, 7, 8'hFF, 7'h7F, 1'b1});
        vecs.push_back('{32'h00000000, 1'b1, 1'b0, 0, 8'hFE, 7'h40, 1'b1});
        vecs.push_back('{32'h00000000, 1'b1, 1'b0, 1, 8'hFF, 7'h7F, 1'b1});
        vecs.push_back('{32'h00000000, 1'b1, 1'b0, 7, 8'hFF, 7'h7F, 1'b1});
        vecs.push_back('{32'h80000000, 1'b1, 1'b0, 0, 8'hFE, 7'h40, 1'b1});
        vecs.push_back('{32'h80000000, 1'b1, 1'b0, 3, 8'hF7, 7'h40, 1'b1});
        vecs.push_back('{32'h80000000, 1'b1, 1'b0, 7, 8'h7F, 7'h00, 1'b1});
        vecs.push_back('{32'h56789EF0, 1'b1, 1'b0, 0, 8'hFE, 7'h40, 1'b1});
        vecs.push_back('{32'h56789EF0, 1'b1, 1'b0, 1, 8'hFD, 7'h0E, 1'b1});
        vecs.push_back('{32'h56789EF0, 1'b1, 1'b0, 2, 8'hFB, 7'h06, 1'b1});
        vecs.push_back('{32'h56789EF0, 1'b1, 1'b0, 3, 8'hF7, 7'h10, 1'b1});
        vecs.push_back('{32'h56789EF0, 1'b1, 1'b0, 4, 8'hEF, 7'h00, 1'b1});
        vecs.push_back('{32'h56789EF0, 1'b1, 1'b0, 5, 8'hDF, 7'h78, 1'b1});
        vecs.push_back('{32'h56789EF0, 1'b1, 1'b0, 6, 8'hBF, 7'h02, 1'b1});
        vecs.push_back('{32'h56789EF0, 1'b1, 1'b0, 7, 8'h7F, 7'h12, 1'b1});
        vecs.push_back('{32'h1234ABCD, 1'b0, 1'b1, 0, 8'hFE, 7'h21, 1'b0});
        vecs.push_back('{32'h1234ABCD, 1'b0, 1'b1, 3, 8'hF7, 7'h08, 1'b1});
        vecs.push_back('{32'h00000000, 1'b1, 1'b1, 1, 8'hFF, 7'h7F, 1'b1});

        scan_seg[0] = 7'h21; scan_seg[1] = 7'h46; scan_seg[2] = 7'h03; scan_seg[3] = 7'h08;
        scan_seg[4] = 7'h19; scan_seg[5] = 7'h30; scan_seg[6] = 7'h24; scan_seg[7] = 7'h79;

        // Reset values while held, first digit after release, first frame timing.
        bus.value = 32'h0; bus.blank_lz = 1'b0; bus.dp_flag = 1'b0;
        rst = 1'b1;
        step(3);
        check("rst_an",    32'(bus.an),    32'hFF);
        check("rst_seg",   32'(bus.seg),   32'h7F);
        check("rst_dp",    32'(bus.dp),    32'h1);
        check("rst_frame", 32'(bus.frame), 32'h0);
        rst = 1'b0;
        step(1);
        check("rel_an",  32'(bus.an),  32'hFE);
        check("rel_seg", 32'(bus.seg), 32'h40);
        s = 1;
        while (bus.frame !== 1'b1 && s < 100) begin
            step(1);
            s++;
        end
        check("first_frame_cycle", 32'(s), 32'd32);
        step(1);
        check("frame_one_cycle", 32'(bus.frame), 32'h0);

        // Table-driven vectors.
        foreach (vecs[k]) begin
            do_reset(vecs[k].value, vecs[k].blz, vecs[k].dpf);
            wait_frame("vec_frame", s);
            step(2 + 4 * vecs[k].digit);
            check($sformatf("vec%0d_an", k),  32'(bus.an),  32'(vecs[k].an));
            check($sformatf("vec%0d_seg", k), 32'(bus.seg), 32'(vecs[k].seg));
            check($sformatf("vec%0d_dp", k),  32'(bus.dp),  32'(vecs[k].dp));
        end

        // Scan order and dwell: every cycle of a frame, each digit held 4 cycles.
        do_reset(32'h1234ABCD, 1'b0, 1'b0);
        wait_frame("scan_frame", s);
        for (int d = 0; d < 8; d++) begin
            e_an = ~(8'h01 << d);
            for (int c = 0; c < 4; c++) begin
                step(1);
                check($sformatf("scan_d%0d_c%0d_an", d, c), 32'(bus.an), 32'(e_an));
                check($sformatf("scan_d%0d_c%0d_seg", d, c), 32'(bus.seg), 32'(scan_seg[d]));
            end
        end

        // Tear-free update: change value while digit 3 is scanning.
        do_reset(32'h1234ABCD, 1'b0, 1'b0);
        wait_frame("tear_frame", s);
        step(13);
        check("tear_at_d3_an", 32'(bus.an), 32'hF7);
        bus.value = 32'hFFFFFFFF;
        for (int d = 4; d < 8; d++) begin
            step(4);
            check($sformatf("tear_old_d%0d_seg", d), 32'(bus.seg), 32'(scan_seg[d]));
        end
        wait_frame("tear_frame2", s);
        for (int d = 0; d < 8; d++) begin
            step(d == 0 ? 2 : 4);
            check($sformatf("tear_new_d%0d_seg", d), 32'(bus.seg), 32'h0E);
        end

        // Decimal point follows dp_flag live within digit 0.
        do_reset(32'h0, 1'b0, 1'b1);
        wait_frame("dp_frame", s);
        step(1);
        check("dp_on_an", 32'(bus.an), 32'hFE);
        check("dp_on",    32'(bus.dp), 32'h0);
        bus.dp_flag = 1'b0;
        step(1);
        check("dp_drop_an", 32'(bus.an), 32'hFE);
        check("dp_drop",    32'(bus.dp), 32'h1);

        // Mid-frame reset while digit 5 is scanning.
        do_reset(32'h1234ABCD, 1'b0, 1'b0);
        wait_frame("mid_frame", s);
        step(21);
        check("mid_at_d5_an", 32'(bus.an), 32'hDF);
        rst = 1'b1;
        step(1);
        check("mid_rst_an",    32'(bus.an),    32'hFF);
        check("mid_rst_seg",   32'(bus.seg),   32'h7F);
        check("mid_rst_frame", 32'(bus.frame), 32'h0);
        rst = 1'b0;
        step(1);
        check("mid_rel_an",  32'(bus.an),  32'hFE);
        check("mid_rel_seg", 32'(bus.seg), 32'h40);
        s = 1;
        while (bus.frame !== 1'b1 && s < 100) begin
            step(1);
            s++;
        end
        check("mid_next_frame_cycle", 32'(s), 32'd32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
